// File: rtl/mem_stage_if.sv
// Data bus between the memory stage and an SRAM-like slave.
//   master: drives data_req/wr/size/addr/wstrb/wdata, receives addr_ok/data_ok/rdata
//   slave : the reverse
// data_size encoding: 0=byte, 1=half, 2=word.
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the E->M pipeline register, issues one load/store at a
// time on the data bus, captures the raw load word and takes part in the valid/allowin chain.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   respon                exception/eret response, flushes this stage
//   E_to_M_valid/M_allowin  upstream handshake
//   M_to_W_valid/W_allowin  downstream handshake
//   pcE, ALUoutE, storeDataE, MemReadE, MemWriteE, MemSizeE, ctrlE   execute-side fields
//   pcM, ALUoutM, MemDataM, ctrlM                                    registered results
//   data_bus              SRAM-like request/addr_ok/data_ok bus (master side)
module mem_stage #(
  parameter int unsigned CTRL_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              respon,
  input  logic              E_to_M_valid,
  input  logic              W_allowin,
  output logic              M_allowin,
  output logic              M_to_W_valid,
  input  logic [31:0]       pcE,
  input  logic [31:0]       ALUoutE,
  input  logic [31:0]       storeDataE,
  input  logic              MemReadE,
  input  logic              MemWriteE,
  input  logic [1:0]        MemSizeE,
  input  logic [CTRL_W-1:0] ctrlE,
  output logic [31:0]       pcM,
  output logic [31:0]       ALUoutM,
  output logic [31:0]       MemDataM,
  output logic [CTRL_W-1:0] ctrlM,
  mem_stage_if.master       data_bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic              drain_q, drain_d;
  logic              req_q, req_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       sd_q, sd_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       mem_data_q, mem_data_d;

  logic memop;
  logic ready_go;
  logic flush;
  logic capture;

  assign memop    = rd_q | wr_q;
  assign ready_go = !memop || (state_q == StDone) || ((state_q == StWait) && data_bus.data_data_ok);
  assign flush    = drain_q | respon;

  assign M_to_W_valid = m_valid_q & ready_go & !respon;
  assign M_allowin    = !drain_q & (!m_valid_q | (ready_go & W_allowin));

  assign pcM      = pc_q;
  assign ALUoutM  = alu_q;
  assign MemDataM = mem_data_q;
  assign ctrlM    = ctrl_q;

  // Pipeline register. A flush drops both the held and any incoming instruction.
  always_comb begin
    m_valid_d = m_valid_q;
    pc_d      = pc_q;
    alu_d     = alu_q;
    sd_d      = sd_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    size_d    = size_q;
    ctrl_d    = ctrl_q;
    if (M_allowin) begin
      m_valid_d = E_to_M_valid;
      pc_d      = pcE;
      alu_d     = ALUoutE;
      sd_d      = storeDataE;
      rd_d      = MemReadE;
      wr_d      = MemWriteE;
      size_d    = MemSizeE;
      ctrl_d    = ctrlE;
    end
    if (respon) begin
      m_valid_d = 1'b0;
    end
  end

  // Bus FSM. A request cannot be withdrawn, so a flush while requesting raises drain at once:
  // this blocks M_allowin and keeps the request fields stable until the transaction completes.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    drain_d    = drain_q;
    mem_data_d = mem_data_q;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m_valid_q && memop && !respon) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        drain_d = flush;
        if (data_bus.data_addr_ok) begin
          req_d = 1'b0;
          if (data_bus.data_data_ok) begin
            if (flush) begin
              state_d = StIdle;
              drain_d = 1'b0;
            end else begin
              state_d = StDone;
              capture = 1'b1;
            end
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_bus.data_data_ok) begin
          if (flush) begin
            state_d = StIdle;
            drain_d = 1'b0;
          end else begin
            capture = 1'b1;
            // If W takes the result this cycle the instruction leaves; otherwise hold it.
            state_d = W_allowin ? StIdle : StDone;
          end
        end else if (respon) begin
          drain_d = 1'b1;
        end
      end
      StDone: begin
        if (respon || W_allowin) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (capture && rd_q) begin
      mem_data_d = data_bus.data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      m_valid_q  <= 1'b0;
      drain_q    <= 1'b0;
      req_q      <= 1'b0;
      pc_q       <= '0;
      alu_q      <= '0;
      sd_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= '0;
      ctrl_q     <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      drain_q    <= drain_d;
      req_q      <= req_d;
      pc_q       <= pc_d;
      alu_q      <= alu_d;
      sd_q       <= sd_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      ctrl_q     <= ctrl_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Bus fields come straight from the held register, which cannot change while data_req=1.
  always_comb begin
    data_bus.data_req   = req_q;
    data_bus.data_wr    = wr_q;
    data_bus.data_addr  = alu_q;
    data_bus.data_size  = 2'd2;
    data_bus.data_wstrb = 4'b1111;
    data_bus.data_wdata = sd_q;
    case (size_q)
      2'd1: begin
        data_bus.data_size  = 2'd1;
        data_bus.data_wstrb = alu_q[1] ? 4'b1100 : 4'b0011;
        data_bus.data_wdata = {2{sd_q[15:0]}};
      end
      2'd2: begin
        data_bus.data_size  = 2'd0;
        data_bus.data_wstrb = 4'b0001 << alu_q[1:0];
        data_bus.data_wdata = {4{sd_q[7:0]}};
      end
      default: begin
        data_bus.data_addr = {alu_q[31:2], 2'b00};
      end
    endcase
    if (!wr_q) begin
      data_bus.data_wstrb = 4'b0000;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        respon;
  logic        E_to_M_valid;
  logic        W_allowin;
  logic        M_allowin;
  logic        M_to_W_valid;
  logic [31:0] pcE, ALUoutE, storeDataE;
  logic        MemReadE, MemWriteE;
  logic [1:0]  MemSizeE;
  logic [23:0] ctrlE;
  logic [31:0] pcM, ALUoutM, MemDataM;
  logic [23:0] ctrlM;

  int n_checks;
  int n_fails;

  mem_stage_if bus ();

  mem_stage #(
    .CTRL_W (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .respon       (respon),
    .E_to_M_valid (E_to_M_valid),
    .W_allowin    (W_allowin),
    .M_allowin    (M_allowin),
    .M_to_W_valid (M_to_W_valid),
    .pcE          (pcE),
    .ALUoutE      (ALUoutE),
    .storeDataE   (storeDataE),
    .MemReadE     (MemReadE),
    .MemWriteE    (MemWriteE),
    .MemSizeE     (MemSizeE),
    .ctrlE        (ctrlE),
    .pcM          (pcM),
    .ALUoutM      (ALUoutM),
    .MemDataM     (MemDataM),
    .ctrlM        (ctrlM),
    .data_bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks happen at negedge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                       input logic rd, input logic wr, input logic [1:0] sz);
    E_to_M_valid = 1'b1;
    pcE          = pc;
    ALUoutE      = alu;
    storeDataE   = sd;
    MemReadE     = rd;
    MemWriteE    = wr;
    MemSizeE     = sz;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1; respon = 1'b0; E_to_M_valid = 1'b0; W_allowin = 1'b1;
    pcE = '0; ALUoutE = '0; storeDataE = '0; MemReadE = 1'b0; MemWriteE = 1'b0;
    MemSizeE = '0; ctrlE = 24'hABCDEF;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    next();
    next();
    at_neg();
    check_eq("rst_mtow", 32'(M_to_W_valid), 32'd0);
    check_eq("rst_allowin", 32'(M_allowin), 32'd1);
    check_eq("rst_req", 32'(bus.data_req), 32'd0);
    check_eq("rst_pc", pcM, 32'd0);
    check_eq("rst_memdata", MemDataM, 32'd0);
    next();
    reset = 1'b0;

    // Non-memory ALU op completes in one cycle.
    issue(32'h400, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd0);
    next();
    E_to_M_valid = 1'b0;
    at_neg();
    check_eq("alu_mtow", 32'(M_to_W_valid), 32'd1);
    check_eq("alu_out", ALUoutM, 32'h1234);
    check_eq("alu_pc", pcM, 32'h400);
    check_eq("alu_ctrl", 32'(ctrlM), 32'hABCDEF);
    check_eq("alu_req", 32'(bus.data_req), 32'd0);
    next();
    at_neg();
    check_eq("alu_gone", 32'(M_to_W_valid), 32'd0);
    check_eq("alu_req2", 32'(bus.data_req), 32'd0);

    // Load word at 0x100: addr_ok two cycles after req, data_ok three cycles after that.
    issue(32'h404, 32'h100, 32'h0, 1'b1, 1'b0, 2'd0);
    next();
    E_to_M_valid = 1'b0;
    at_neg();
    check_eq("ld_latch_req", 32'(bus.data_req), 32'd0);
    check_eq("ld_latch_allowin", 32'(M_allowin), 32'd0);
    next();
    at_neg();
    check_eq("ld_req", 32'(bus.data_req), 32'd1);
    check_eq("ld_addr", bus.data_addr, 32'h100);
    check_eq("ld_size", 32'(bus.data_size), 32'd2);
    check_eq("ld_wr", 32'(bus.data_wr), 32'd0);
    check_eq("ld_wstrb", 32'(bus.data_wstrb), 32'd0);
    next();
    at_neg();
    check_eq("ld_req_hold", 32'(bus.data_req), 32'd1);
    check_eq("ld_addr_hold", bus.data_addr, 32'h100);
    next();
    bus.data_addr_ok = 1'b1;
    at_neg();
    check_eq("ld_req_aok", 32'(bus.data_req), 32'd1);
    check_eq("ld_mtow_req", 32'(M_to_W_valid), 32'd0);
    next();
    bus.data_addr_ok = 1'b0;
    at_neg();
    check_eq("ld_req_drop", 32'(bus.data_req), 32'd0);
    check_eq("ld_wait_mtow", 32'(M_to_W_valid), 32'd0);
    check_eq("ld_wait_allowin", 32'(M_allowin), 32'd0);
    next();
    next();
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hDEADBEEF;
    at_neg();
    check_eq("ld_dok_mtow", 32'(M_to_W_valid), 32'd1);
    check_eq("ld_dok_allowin", 32'(M_allowin), 32'd1);
    next();
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    at_neg();
    check_eq("ld_memdata", MemDataM, 32'hDEADBEEF);
    check_eq("ld_after_mtow", 32'(M_to_W_valid), 32'd0);

    // Store byte 0xA5 to 0x203 with addr_ok and data_ok together.
    issue(32'h408, 32'h203, 32'h000000A5, 1'b0, 1'b1, 2'd2);
    next();
    E_to_M_valid = 1'b0;
    next();
    bus.data_addr_ok = 1'b1;
    bus.data_data_ok = 1'b1;
    at_neg();
    check_eq("sb_req", 32'(bus.data_req), 32'd1);
    check_eq("sb_wstrb", 32'(bus.data_wstrb), 32'b1000);
    check_eq("sb_wdata", bus.data_wdata, 32'hA5A5A5A5);
    check_eq("sb_size", 32'(bus.data_size), 32'd0);
    check_eq("sb_wr", 32'(bus.data_wr), 32'd1);
    check_eq("sb_addr", bus.data_addr, 32'h203);
    check_eq("sb_req_mtow", 32'(M_to_W_valid), 32'd0);
    next();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    // Following store half enters while the byte store sits in DONE.
    issue(32'h40C, 32'h202, 32'h1234BEEF, 1'b0, 1'b1, 2'd1);
    at_neg();
    check_eq("sb_done_mtow", 32'(M_to_W_valid), 32'd1);
    check_eq("sb_done_allowin", 32'(M_allowin), 32'd1);
    check_eq("sb_memdata_kept", MemDataM, 32'hDEADBEEF);
    next();
    E_to_M_valid = 1'b0;
    next();
    bus.data_addr_ok = 1'b1;
    at_neg();
    check_eq("sh_wstrb", 32'(bus.data_wstrb), 32'b1100);
    check_eq("sh_wdata", bus.data_wdata, 32'hBEEFBEEF);
    check_eq("sh_size", 32'(bus.data_size), 32'd1);
    next();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    at_neg();
    check_eq("sh_dok_mtow", 32'(M_to_W_valid), 32'd1);
    next();
    bus.data_data_ok = 1'b0;

    // Load (size 3 treated as word, unaligned addr forced down); W stalls at data_ok.
    issue(32'h410, 32'h107, 32'h0, 1'b1, 1'b0, 2'd3);
    next();
    E_to_M_valid = 1'b0;
    next();
    bus.data_addr_ok = 1'b1;
    at_neg();
    check_eq("lw3_addr", bus.data_addr, 32'h104);
    check_eq("lw3_size", 32'(bus.data_size), 32'd2);
    next();
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h13579BDF;
    W_allowin        = 1'b0;
    at_neg();
    check_eq("stall_dok_mtow", 32'(M_to_W_valid), 32'd1);
    check_eq("stall_dok_allowin", 32'(M_allowin), 32'd0);
    next();
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'hFFFFFFFF;
    at_neg();
    check_eq("stall_done_memdata", MemDataM, 32'h13579BDF);
    check_eq("stall_done_mtow", 32'(M_to_W_valid), 32'd1);
    next();
    at_neg();
    check_eq("stall_hold_memdata", MemDataM, 32'h13579BDF);
    check_eq("stall_hold_mtow", 32'(M_to_W_valid), 32'd1);
    check_eq("stall_hold_allowin", 32'(M_allowin), 32'd0);
    W_allowin = 1'b1;
    issue(32'h414, 32'hCAFE, 32'h0, 1'b0, 1'b0, 2'd0);
    #1;
    check_eq("stall_release_allowin", 32'(M_allowin), 32'd1);
    next();
    E_to_M_valid = 1'b0;
    at_neg();
    check_eq("next_alu_out", ALUoutM, 32'hCAFE);
    check_eq("next_alu_mtow", 32'(M_to_W_valid), 32'd1);
    next();

    // Flush while waiting for data_ok: drained, result discarded.
    issue(32'h418, 32'h300, 32'h0, 1'b1, 1'b0, 2'd0);
    next();
    E_to_M_valid = 1'b0;
    next();
    bus.data_addr_ok = 1'b1;
    next();
    bus.data_addr_ok = 1'b0;
    respon = 1'b1;
    at_neg();
    check_eq("fl_resp_mtow", 32'(M_to_W_valid), 32'd0);
    next();
    respon = 1'b0;
    at_neg();
    check_eq("fl_drain_allowin", 32'(M_allowin), 32'd0);
    check_eq("fl_drain_mtow", 32'(M_to_W_valid), 32'd0);
    next();
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h55555555;
    at_neg();
    check_eq("fl_dok_mtow", 32'(M_to_W_valid), 32'd0);
    check_eq("fl_dok_allowin", 32'(M_allowin), 32'd0);
    next();
    bus.data_data_ok = 1'b0;
    at_neg();
    check_eq("fl_memdata", MemDataM, 32'h13579BDF);
    check_eq("fl_allowin_back", 32'(M_allowin), 32'd1);

    // Flush with an incoming instruction drops it.
    issue(32'h41C, 32'h9999, 32'h0, 1'b0, 1'b0, 2'd0);
    respon = 1'b1;
    next();
    respon = 1'b0;
    E_to_M_valid = 1'b0;
    at_neg();
    check_eq("fl_drop_mtow", 32'(M_to_W_valid), 32'd0);

    // Reset while requesting.
    next();
    issue(32'h420, 32'h500, 32'h0, 1'b1, 1'b0, 2'd0);
    next();
    E_to_M_valid = 1'b0;
    next();
    at_neg();
    check_eq("rq_req", 32'(bus.data_req), 32'd1);
    reset = 1'b1;
    next();
    reset = 1'b0;
    at_neg();
    check_eq("rq_rst_req", 32'(bus.data_req), 32'd0);
    check_eq("rq_rst_mtow", 32'(M_to_W_valid), 32'd0);
    check_eq("rq_rst_allowin", 32'(M_allowin), 32'd1);
    check_eq("rq_rst_alu", ALUoutM, 32'd0);
    check_eq("rq_rst_pc", pcM, 32'd0);
    check_eq("rq_rst_memdata", MemDataM, 32'd0);
    check_eq("rq_rst_ctrl", 32'(ctrlM), 32'd0);
    next();
    at_neg();
    check_eq("rq_rst_stay_idle", 32'(bus.data_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
